// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX operand bundle and EX result bundle
//
// Purpose: carries one instruction's operands into the execute stage and its
// result back out to EX/MEM.
// Ports (signals):
//   aluop[2:0], alufun[3:0]  operation class and operation select
//   reg1[31:0], reg2[31:0]   operands
//   wd[4:0], wreg            destination address and write enable
//   annul                    flush the instruction currently in EX
//   wd_o[4:0], wreg_o        destination passed through, qualified enable
//   wdata_o[31:0]            result
//   stallreq                 hold upstream, bubble downstream
// Modports: master drives the instruction, slave is the execute stage.
interface ex_stage_if;
  logic [2:0]  aluop;
  logic [3:0]  alufun;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic        annul;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  modport master (
    output aluop, alufun, reg1, reg2, wd, wreg, annul,
    input  wd_o, wreg_o, wdata_o, stallreq
  );

  modport slave (
    input  aluop, alufun, reg1, reg2, wd, wreg, annul,
    output wd_o, wreg_o, wdata_o, stallreq
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, multiplier, iterative divider
//
// Purpose: computes ALU and multiply results in the same cycle; divides use a
// 32-step restoring divider that stalls the pipeline for 33 cycles.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   ex   ex_stage_if.slave (operands in, result/stall out)
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex
);
  localparam logic [2:0] OP_ALU    = 3'b001;
  localparam logic [2:0] OP_MULDIV = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] quo;      // dividend shifts out, quotient shifts in
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q, neg_r, is_rem;

  // ALU
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  assign shamt = ex.reg2[4:0];

  always_comb begin
    alu_res = '0;
    case (ex.alufun)
      4'd0: alu_res = ex.reg1 + ex.reg2;
      4'd1: alu_res = ex.reg1 - ex.reg2;
      4'd2: alu_res = ex.reg1 << shamt;
      4'd3: alu_res = {31'b0, $signed(ex.reg1) < $signed(ex.reg2)};
      4'd4: alu_res = {31'b0, ex.reg1 < ex.reg2};
      4'd5: alu_res = ex.reg1 ^ ex.reg2;
      4'd6: alu_res = ex.reg1 >> shamt;
      4'd7: alu_res = $signed(ex.reg1) >>> shamt;
      4'd8: alu_res = ex.reg1 | ex.reg2;
      4'd9: alu_res = ex.reg1 & ex.reg2;
      default: alu_res = '0;
    endcase
  end

  // One 64-bit multiplier; operand extension picks signed/unsigned flavour.
  // MULHU (3) treats reg1 as unsigned, MULHSU/MULHU (2,3) treat reg2 as unsigned.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {(ex.alufun[1:0] == 2'd3) ? 32'b0 : {32{ex.reg1[31]}}, ex.reg1};
  assign mul_b = {ex.alufun[1] ? 32'b0 : {32{ex.reg2[31]}}, ex.reg2};
  assign prod  = mul_a * mul_b;

  // Divide decode: codes 4..7, even codes are signed, codes 6/7 are remainders.
  logic        div_op, div_signed, div_zero, div_ovf, div_start;
  logic [31:0] mag1, mag2;
  assign div_op     = (ex.aluop == OP_MULDIV) && (ex.alufun[3:2] == 2'b01);
  assign div_signed = ~ex.alufun[0];
  assign div_zero   = (ex.reg2 == 32'd0);
  assign div_ovf    = div_signed && (ex.reg1 == 32'h8000_0000) && (ex.reg2 == 32'hFFFF_FFFF);
  assign div_start  = (state == S_IDLE) && div_op && !div_zero && !div_ovf && !ex.annul;
  assign mag1       = (div_signed && ex.reg1[31]) ? -ex.reg1 : ex.reg1;
  assign mag2       = (div_signed && ex.reg2[31]) ? -ex.reg2 : ex.reg2;

  logic [31:0] md_res;
  always_comb begin
    md_res = '0;
    case (ex.alufun)
      4'd0:       md_res = prod[31:0];
      4'd1, 4'd2,
      4'd3:       md_res = prod[63:32];
      // Only the degenerate cases resolve here; normal divides go through the FSM.
      4'd4, 4'd5: md_res = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : 32'd0);
      4'd6, 4'd7: md_res = div_zero ? ex.reg1 : 32'd0;
      default:    md_res = '0;
    endcase
  end

  // Restoring step: bit 32 of the difference is the borrow (trial subtract failed).
  logic [32:0] rem_sh, rem_diff;
  assign rem_sh   = {rem, quo[31]};
  assign rem_diff = rem_sh - {1'b0, dvs};

  logic [31:0] q_fix, r_fix, div_res;
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = is_rem ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else if (div_start) begin
      cnt    <= '0;
      quo    <= mag1;
      rem    <= '0;
      dvs    <= mag2;
      neg_q  <= div_signed && (ex.reg1[31] ^ ex.reg2[31]);
      neg_r  <= div_signed && ex.reg1[31];
      is_rem <= ex.alufun[1];
    end else if (state == S_BUSY) begin
      cnt <= cnt + 5'd1;
      if (!rem_diff[32]) begin
        rem <= rem_diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ex.stallreq = 1'b0;
    ex.wreg_o   = 1'b0;
    ex.wdata_o  = '0;
    ex.wd_o     = ex.wd;

    case (state)
      S_IDLE:  if (div_start) state_nx = S_BUSY;
      S_BUSY:  if (cnt == 5'd31) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (ex.annul) state_nx = S_IDLE;

    if (rst) begin
      ex.wd_o = '0;
    end else if (!ex.annul) begin
      case (state)
        S_IDLE: begin
          if (div_start) begin
            ex.stallreq = 1'b1;
          end else if (ex.aluop == OP_ALU) begin
            ex.wreg_o  = ex.wreg;
            ex.wdata_o = alu_res;
          end else if (ex.aluop == OP_MULDIV) begin
            ex.wreg_o  = ex.wreg;
            ex.wdata_o = md_res;
          end
        end
        S_BUSY: ex.stallreq = 1'b1;
        S_DONE: begin
          ex.wreg_o  = ex.wreg;
          ex.wdata_o = div_res;
        end
        default: ex.stallreq = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: results straight from the ISA definitions using 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [3:0] fn,
                                               input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 3'd1) begin
      case (fn)
        4'd0: return a + b;
        4'd1: return a - b;
        4'd2: return a << b[4:0];
        4'd3: return (sa < sb) ? 32'd1 : 32'd0;
        4'd4: return (ua < ub) ? 32'd1 : 32'd0;
        4'd5: return a ^ b;
        4'd6: return a >> b[4:0];
        4'd7: begin p = sa >>> b[4:0]; return p[31:0]; end
        4'd8: return a | b;
        4'd9: return a & b;
        default: return 32'd0;
      endcase
    end
    if (op == 3'd2) begin
      case (fn)
        4'd0: begin p = sa * sb; return p[31:0]; end
        4'd1: begin p = sa * sb; return p[63:32]; end
        4'd2: begin p = sa * longint'(ub); return p[63:32]; end
        4'd3: begin p = ua * ub; return p[63:32]; end
        4'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
        4'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
        4'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
        4'd7: begin if (b == 0) return a; return a % b; end
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic bit model_stalls(input logic [2:0] op, input logic [3:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
    bit is_div, signed_op;
    is_div    = (op == 3'd2) && (fn >= 4'd4) && (fn <= 4'd7);
    signed_op = (fn == 4'd4) || (fn == 4'd6);
    if (!is_div || b == 0) return 1'b0;
    if (signed_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pick_operand();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [3:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] w, input logic we);
    bus.aluop  = op;
    bus.alufun = fn;
    bus.reg1   = a;
    bus.reg2   = b;
    bus.wd     = w;
    bus.wreg   = we;
    bus.annul  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a later rising edge.
  task automatic run_op(input logic [2:0] op, input logic [3:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] w, input logic we,
                        input string tag);
    logic [31:0] exp_data;
    logic        exp_wreg;
    int          n;
    exp_data = model_result(op, fn, a, b);
    exp_wreg = (op == 3'd1 || op == 3'd2) ? we : 1'b0;
    drive(op, fn, a, b, w, we);
    @(negedge clk);
    if (model_stalls(op, fn, a, b)) begin
      n = 0;
      while (bus.stallreq === 1'b1 && n < 40) begin
        if (bus.wreg_o !== 1'b0 || bus.wdata_o !== 32'd0)
          check({tag, "_stall_out"}, {bus.wdata_o[30:0], bus.wreg_o}, 32'd0);
        n++;
        step();
        bus.reg1 = $urandom;
        bus.reg2 = $urandom;
        @(negedge clk);
      end
      check({tag, "_stall_len"}, 32'(n), 32'd33);
    end else begin
      check({tag, "_stall"}, 32'(bus.stallreq), 32'd0);
    end
    check({tag, "_wdata"}, bus.wdata_o, exp_data);
    check({tag, "_wreg"}, 32'(bus.wreg_o), 32'(exp_wreg));
    check({tag, "_wd"}, 32'(bus.wd_o), 32'(w));
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wreg"}, 32'(bus.wreg_o), 32'd0);
    check({tag, "_wdata"}, bus.wdata_o, 32'd0);
    check({tag, "_stall"}, 32'(bus.stallreq), 32'd0);
    check({tag, "_wd"}, 32'(bus.wd_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [3:0] fn;
    rst = 1'b1;
    drive(3'd2, 4'd4, 32'd100, 32'd7, 5'd9, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check_all_zero("rst_div");
    step();
    drive(3'd1, 4'd0, 32'd1, 32'd2, 5'd17, 1'b1);
    @(negedge clk);
    check_all_zero("rst_add");
    step();
    rst = 1'b0;

    run_op(3'd1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd1, 1'b1, "add_wrap");
    run_op(3'd1, 4'd7, 32'h8000_0000, 32'd4, 5'd2, 1'b1, "sra");
    run_op(3'd1, 4'd4, 32'd1, 32'hFFFF_FFFF, 5'd3, 1'b1, "sltu");
    run_op(3'd2, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1, "mulh");
    run_op(3'd2, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, "mulhu");
    run_op(3'd2, 4'd4, 32'd100, 32'd7, 5'd6, 1'b1, "div");
    run_op(3'd2, 4'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, "rem");
    run_op(3'd2, 4'd5, $urandom, 32'd0, 5'd8, 1'b1, "divu_zero");
    run_op(3'd2, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, "div_ovf");
    run_op(3'd2, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, "rem_ovf");
    run_op(3'd0, 4'd0, 32'd5, 32'd6, 5'd11, 1'b1, "nop");
    run_op(3'd1, 4'd12, 32'd5, 32'd6, 5'd12, 1'b1, "alu_undef");
    run_op(3'd2, 4'd9, 32'd5, 32'd6, 5'd13, 1'b1, "md_undef");

    for (int i = 0; i < 200; i++) begin
      int r;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(0, 7));
      fn = (op == 3'd2) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      run_op(op, fn, pick_operand(), pick_operand(), 5'($urandom), 1'($urandom), "rand");
    end

    // Flush in the tenth BUSY cycle.
    drive(3'd2, 4'd4, 32'd1000, 32'd3, 5'd14, 1'b1);
    @(negedge clk);
    check("annul_issue_stall", 32'(bus.stallreq), 32'd1);
    repeat (10) step();
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_busy_stall", 32'(bus.stallreq), 32'd0);
    check("annul_busy_wreg", 32'(bus.wreg_o), 32'd0);
    step();
    run_op(3'd1, 4'd0, 32'd2, 32'd3, 5'd15, 1'b1, "after_annul");

    // Flush on the issue cycle must keep the divider idle.
    drive(3'd2, 4'd4, 32'd100, 32'd7, 5'd16, 1'b1);
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_idle_stall", 32'(bus.stallreq), 32'd0);
    check("annul_idle_wreg", 32'(bus.wreg_o), 32'd0);
    step();
    run_op(3'd1, 4'd1, 32'd10, 32'd4, 5'd17, 1'b1, "after_annul_idle");

    // Reset in the fifth BUSY cycle abandons the divide.
    drive(3'd2, 4'd4, 32'd100, 32'd7, 5'd18, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    step();
    rst = 1'b0;
    run_op(3'd2, 4'd5, 32'd9, 32'd3, 5'd19, 1'b1, "divu_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port aluop, input, 3 bits: 000 NOP, 001 ALU, 010 MULDIV; all others are treated as NOP.
REQ-004 SHALL have port alufun, input, 4 bits: operation select within aluop.
REQ-005 SHALL have ports reg1 and reg2, input, 32 bits each: operands from the ID/EX register.
REQ-006 SHALL have port wd, input, 5 bits: destination register address.
REQ-007 SHALL have port wreg, input, 1 bit: destination write enable.
REQ-008 SHALL have port annul, input, 1 bit: pipeline flush of the instruction in EX.
REQ-009 SHALL have port wd_o, output, 5 bits: wd passed through.
REQ-010 SHALL have port wreg_o, output, 1 bit: qualified write enable.
REQ-011 SHALL have port wdata_o, output, 32 bits: result.
REQ-012 SHALL have port stallreq, output, 1 bit: request to hold all upstream stages and insert a bubble downstream.

Function
REQ-013 ALU alufun SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; shift amount is reg2[4:0]; codes 10-15 give wdata_o=0.
REQ-014 MULDIV alufun SHALL be: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; codes 8-15 give wdata_o=0.
REQ-015 ALU ops and codes 0-3 SHALL be combinational, with wdata_o valid in the same cycle and no stall.
REQ-016 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32] of the 64-bit signed x signed, signed x unsigned, and unsigned x unsigned product respectively.
REQ-017 Divides SHALL use a divider FSM with states IDLE, BUSY, DONE, plus a 5-bit iteration counter.
REQ-018 IDLE, divide op presented, divisor nonzero, no overflow: the block SHALL assert stallreq, latch operand magnitudes and sign flags, clear the counter, and go to BUSY.
REQ-019 BUSY: the block SHALL perform one restoring quotient bit per cycle, holding stallreq=1; after counter=31 it SHALL go to DONE (32 BUSY cycles).
REQ-020 DONE: the block SHALL drive the sign-corrected result on wdata_o with stallreq=0, then return to IDLE unconditionally.
REQ-021 Stall span: stallreq SHALL be 1 for exactly 33 cycles (issue + 32 BUSY) and the result SHALL appear in the 34th cycle.
REQ-022 Divide by zero SHALL complete combinationally with no stall: DIV/DIVU give 0xFFFFFFFF; REM/REMU give reg1.
REQ-023 Signed overflow (reg1=0x80000000, reg2=0xFFFFFFFF) SHALL complete combinationally with no stall: DIV gives 0x80000000; REM gives 0.
REQ-024 Signed results SHALL follow RISC-V rules: the quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
REQ-025 The block SHALL ignore reg1/reg2 changes while in BUSY, using latched values only.
REQ-026 While stallreq=1, wreg_o SHALL be 0 and wdata_o SHALL be 0; otherwise wreg_o=wreg and wd_o=wd.
REQ-027 annul=1 SHALL force the FSM to IDLE next cycle and drive stallreq=0, wreg_o=0 in the current cycle.
REQ-028 annul=1 in IDLE SHALL suppress the start of a divide.
REQ-029 aluop NOP SHALL give wdata_o=0 and wreg_o=0.

Reset
REQ-030 With rst=1 at a rising edge, the FSM SHALL go to IDLE and the counter and latched operands SHALL be cleared.
REQ-031 While rst=1, the outputs SHALL be wreg_o=0, wdata_o=0, stallreq=0 and wd_o=0.
REQ-032 A reset asserted mid-division SHALL abandon the division with no result produced.

Verification
REQ-033 ALU ADD 0x7FFFFFFF+1 -> wdata_o=0x80000000 same cycle; SRA 0x80000000>>4 -> 0xF8000000; SLTU 1,0xFFFFFFFF -> 1.
REQ-034 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0; MULHU same operands -> 0xFFFFFFFE; no stall.
REQ-035 DIV 100,7 -> stallreq high 33 cycles, wreg_o=0 during stall; cycle 34 wdata_o=14, wreg_o=1; REM -7,2 -> 0xFFFFFFFF.
REQ-036 DIVU x,0 -> 0xFFFFFFFF with no stall; DIV 0x80000000,-1 -> 0x80000000; REM same operands -> 0.
REQ-037 DIV started, annul at BUSY cycle 10 -> stallreq=0 that cycle, FSM IDLE next cycle; following ADD 2+3 -> 5 without stall.
REQ-038 DIV started, rst at BUSY cycle 5 -> all outputs 0; after release a new DIVU 9,3 -> 3 after 33 stall cycles.
